fir_scie_sequencer: RTL

//   Sequences the pipelined SCIE FIR datapath on behalf of a streaming client. Converts

---
 rtl/fir_scie_sequencer_if.sv | 58 +++++
 rtl/fir_scie_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fir_scie_sequencer_if.sv
// ============================================================================
// fir_scie_sequencer_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles the three client streams and the SCIE datapath bus that
//   fir_scie_sequencer sits between.
// Signals:
//   cfg_valid/cfg_ready/cfg_idx/cfg_coef   coefficient-write stream
//   in_valid/in_ready/in_sample            sample stream
//   out_valid/out_ready/out_data           result stream
//   scie_valid/scie_insn/scie_rs1/scie_rs2 custom-instruction issue bus
//   scie_rd                                datapath result
// Modports:
//   slave   the sequencer's view (accepts streams, drives the datapath bus)
//   master  the environment's view (client front-end plus datapath)
// ============================================================================
interface fir_scie_sequencer_if #(
    parameter int IDX_W = 3
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [IDX_W-1:0] cfg_idx;
    logic [31:0]      cfg_coef;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_sample;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;

    logic             scie_valid;
    logic [31:0]      scie_insn;
    logic [31:0]      scie_rs1;
    logic [31:0]      scie_rs2;
    logic [31:0]      scie_rd;

    modport slave (
        input  cfg_valid, cfg_idx, cfg_coef,
        input  in_valid, in_sample,
        input  out_ready,
        input  scie_rd,
        output cfg_ready, in_ready,
        output out_valid, out_data,
        output scie_valid, scie_insn, scie_rs1, scie_rs2
    );

    modport master (
        output cfg_valid, cfg_idx, cfg_coef,
        output in_valid, in_sample,
        output out_ready,
        output scie_rd,
        input  cfg_ready, in_ready,
        input  out_valid, out_data,
        input  scie_valid, scie_insn, scie_rs1, scie_rs2
    );
endinterface

// File: rtl/fir_scie_sequencer.sv
// ============================================================================
// fir_scie_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Drives a pipelined SCIE FIR datapath on behalf of a streaming client.
//   Coefficient writes become a single LOAD issue; each sample becomes
//   PUSH, a bubble of PUSH_TO_READ-1 cycles, READ, and a capture of scie_rd
//   into a one-entry output register.
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-low
//   bus      fir_scie_sequencer_if.slave (cfg/in/out streams + SCIE bus)
//   cfg_err  sticky flag: an out-of-range cfg_idx was accepted and dropped
//   busy     FSM is not in IDLE
// ============================================================================
module fir_scie_sequencer #(
    parameter int         TAPS         = 5,
    parameter int         IDX_W        = 3,
    parameter logic [6:0] OP_LOAD      = 7'h0B,
    parameter logic [6:0] OP_PUSH      = 7'h2B,
    parameter logic [6:0] OP_READ      = 7'h5B,
    parameter int         PUSH_TO_READ = 2,
    parameter int         READ_LAT     = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    fir_scie_sequencer_if.slave    bus,
    output logic                   cfg_err,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PUSH,
        WAIT,
        READ,
        CAPT
    } state_t;

    localparam int MAX_CNT = (PUSH_TO_READ > READ_LAT) ? PUSH_TO_READ : READ_LAT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             out_free;
    logic             idle_ok;
    logic             cfg_take;
    logic             in_take;
    logic             idx_ok;
    logic             wait_done;
    logic             rd_ready;
    logic             capture;

    // run keeps both ready outputs low while reset is asserted and for the
    // first cycle after release, so every output really is 0 in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // A new sample is only taken when the output register can absorb its
    // result, so a result is never overwritten.
    assign out_free  = ~bus.out_valid | bus.out_ready;
    assign idle_ok   = run & (state == IDLE);
    assign idx_ok    = (32'(bus.cfg_idx) < 32'(TAPS));
    assign cfg_take  = idle_ok & bus.cfg_valid;
    assign in_take   = idle_ok & ~bus.cfg_valid & bus.in_valid & out_free;
    assign wait_done = (cnt == CNT_W'(PUSH_TO_READ - 2));
    assign rd_ready  = (cnt >= CNT_W'(READ_LAT - 1));
    assign capture   = (state == CAPT) & rd_ready & out_free;

    assign bus.cfg_ready = idle_ok;
    assign bus.in_ready  = idle_ok & ~bus.cfg_valid & out_free;
    assign busy          = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_take) begin
                    if (idx_ok) begin
                        state_nxt = LOAD;
                    end
                end else if (in_take) begin
                    state_nxt = PUSH;
                end
            end
            LOAD: state_nxt = IDLE;
            PUSH: state_nxt = (PUSH_TO_READ > 1) ? WAIT : READ;
            WAIT: begin
                if (wait_done) begin
                    state_nxt = READ;
                end
            end
            READ: state_nxt = CAPT;
            CAPT: begin
                if (capture) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One counter serves both the WAIT bubble and the READ latency; it
    // restarts on every state change and saturates so a long CAPT stall
    // cannot wrap it back below the latency threshold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The issue bus is registered from the next state, so scie_valid is
    // high exactly during LOAD/PUSH/READ and the operands are taken straight
    // from the stream beat being accepted at that edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.scie_valid <= 1'b0;
            bus.scie_insn  <= '0;
            bus.scie_rs1   <= '0;
            bus.scie_rs2   <= '0;
        end else begin
            bus.scie_valid <= 1'b0;
            bus.scie_insn  <= '0;
            bus.scie_rs1   <= '0;
            bus.scie_rs2   <= '0;
            if (state_nxt == LOAD) begin
                bus.scie_valid <= 1'b1;
                bus.scie_insn  <= {25'b0, OP_LOAD};
                bus.scie_rs1   <= bus.cfg_coef;
                bus.scie_rs2   <= 32'(bus.cfg_idx);
            end else if (state_nxt == PUSH) begin
                bus.scie_valid <= 1'b1;
                bus.scie_insn  <= {25'b0, OP_PUSH};
                bus.scie_rs1   <= bus.in_sample;
            end else if (state_nxt == READ) begin
                bus.scie_valid <= 1'b1;
                bus.scie_insn  <= {25'b0, OP_READ};
            end
        end
    end

    // A capture landing in the same cycle as a consumer handshake refills
    // the register instead of letting out_valid drop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (capture) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.scie_rd;
        end else if (bus.out_valid & bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else if (cfg_take & ~idx_ok) begin
            cfg_err <= 1'b1;
        end
    end

endmodule
